sort_ctrl: RTL

Sequencer for the 10-element serial sort DataPath. It loads the input words, runs recirculating compare/exchange passes, stops after N−1 passes or earlier when a pass changes nothing, then streams the sorted words out. It drives every control strobe of the DataPath and consumes its four status flags. It sits between the system-level start/valid handshake and the DataPath.

---
 rtl/sort_pkg.sv | 31 +++
 rtl/sort_ctrl_if.sv | 31 +++
 rtl/sort_pass_counter.sv | 42 ++++
 rtl/sort_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the serial sort sequencer: FSM state encoding,
// default sizing, and the DataPath control-bundle field order.
package sort_pkg;

  // Words sorted per run (9 shift stages plus the bigger register).
  localparam int unsigned N_ELEM = 10;
  // Width of the pass counter.
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEED,
    S_PASS,
    S_PASS_END,
    S_OUT,
    S_DONE
  } state_t;

  // DataPath control bundle, MSB first.
  typedef struct packed {
    logic en_sr;
    logic mux_in;
    logic wr_bigger;
    logic wr_last;
    logic wr_counter;
    logic rst_counter;
    logic data_valid;
  } ctrl_t;

endpackage

// File: rtl/sort_ctrl_if.sv
// Control/status link between sort_ctrl and the serial sort DataPath.
//   master : sequencer side, drives the strobes and reads the status flags
//   slave  : DataPath side
// Signal suffixes are relative to the sequencer (_o driven by it, _i read by it).
interface sort_ctrl_if;
  // DataPath controls
  logic en_sr_o;
  logic mux_in_o;
  logic wr_bigger_o;
  logic wr_last_o;
  logic wr_counter_o;
  logic rst_counter_o;
  logic data_valid_o;
  // DataPath status flags
  logic eh_maior_i;    // bigger register < shift stage 8
  logic end_comp_i;    // shift stage 8 == last register
  logic end_sft_i;     // bigger register == first register
  logic end_count_i;   // element counter == N_ELEM-1

  modport master (
    output en_sr_o, mux_in_o, wr_bigger_o, wr_last_o,
           wr_counter_o, rst_counter_o, data_valid_o,
    input  eh_maior_i, end_comp_i, end_sft_i, end_count_i
  );

  modport slave (
    input  en_sr_o, mux_in_o, wr_bigger_o, wr_last_o,
           wr_counter_o, rst_counter_o, data_valid_o,
    output eh_maior_i, end_comp_i, end_sft_i, end_count_i
  );
endinterface

// File: rtl/sort_pass_counter.sv
// Saturating up-counter with synchronous clear, used to count completed
// sort passes.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : clear to zero (wins over inc_i)
//   inc_i      : increment, holds at MAX
//   cnt_o      : current count
module sort_pass_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sort_ctrl.sv
// Sequencer for the 10-element serial sort DataPath: loads the input words,
// runs recirculating compare/exchange passes until N_ELEM-1 passes are done
// or a pass changes nothing, then streams the sorted words out.
//   clk, rst    : clock, asynchronous active-low reset
//   start_i     : one-cycle run request, honoured only in IDLE
//   in_valid_i  : input word strobe (only meaningful in LOAD)
//   dp          : DataPath control strobes and status flags
//   busy_o      : high in every state except IDLE
//   done_o      : one-cycle pulse in DONE
//   pass_cnt_o  : passes completed in the current run (saturating)
module sort_ctrl
  import sort_pkg::*;
#(
  parameter int unsigned N_ELEM = sort_pkg::N_ELEM,
  parameter int unsigned CNT_W  = sort_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             in_valid_i,
  sort_ctrl_if.master      dp,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] pass_cnt_o
);

  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(N_ELEM - 1);

  state_t           state_q;
  state_t           state_d;
  ctrl_t            ctrl;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] pass_cnt;

  sort_pass_counter #(
    .WIDTH (CNT_W),
    .MAX   (N_ELEM - 1)
  ) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (pass_cnt)
  );

  // Next state and control decode; outputs follow the state combinationally
  // so an asynchronous reset returns them to IDLE values in the same cycle.
  always_comb begin
    state_d = state_q;
    ctrl    = '0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    done_o  = 1'b0;
    busy_o  = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        ctrl.rst_counter = 1'b1;
        if (start_i) begin
          cnt_clr = 1'b1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        ctrl.en_sr      = in_valid_i;
        ctrl.wr_counter = in_valid_i;
        if (in_valid_i && dp.end_count_i) begin
          state_d = S_SEED;
        end
      end

      S_SEED: begin
        ctrl.wr_bigger   = 1'b1;
        ctrl.rst_counter = 1'b1;
        ctrl.wr_last     = 1'b1;
        state_d          = S_PASS;
      end

      S_PASS: begin
        ctrl.en_sr      = 1'b1;
        ctrl.mux_in     = 1'b1;
        ctrl.wr_counter = 1'b1;
        ctrl.wr_bigger  = dp.eh_maior_i;
        if (dp.end_count_i) begin
          state_d = S_PASS_END;
        end
      end

      S_PASS_END: begin
        ctrl.rst_counter = 1'b1;
        ctrl.wr_last     = 1'b1;
        cnt_inc          = 1'b1;
        // Exit test uses the count as it will be after this pass.
        if (dp.end_sft_i && dp.end_comp_i) begin
          state_d = S_OUT;
        end else if (pass_cnt >= (LAST_PASS - CNT_W'(1))) begin
          state_d = S_OUT;
        end else begin
          state_d = S_PASS;
        end
      end

      S_OUT: begin
        ctrl.en_sr      = 1'b1;
        ctrl.mux_in     = 1'b1;
        ctrl.wr_bigger  = 1'b1;
        ctrl.wr_counter = 1'b1;
        ctrl.data_valid = 1'b1;
        if (dp.end_count_i) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_o           = 1'b1;
        ctrl.rst_counter = 1'b1;
        state_d          = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign dp.en_sr_o       = ctrl.en_sr;
  assign dp.mux_in_o      = ctrl.mux_in;
  assign dp.wr_bigger_o   = ctrl.wr_bigger;
  assign dp.wr_last_o     = ctrl.wr_last;
  assign dp.wr_counter_o  = ctrl.wr_counter;
  assign dp.rst_counter_o = ctrl.rst_counter;
  assign dp.data_valid_o  = ctrl.data_valid;
  assign pass_cnt_o       = pass_cnt;

endmodule
